// File: rtl/combo_sweep_ctrl.sv
`timescale 1ns/1ps
// combo_sweep_ctrl: self-test sequencer for the combo datapath.
// Walks {a,b,c,d} through 0..15, captures o_i into a truth table, checks it.
module combo_sweep_ctrl #(
    parameter int          SETTLE   = 1,
    parameter logic [15:0] EXPECTED = 16'h0999
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        o_i,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        pass
);

    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     idx_q, idx_d;
    logic [SW-1:0]  settle_q, settle_d;
    logic [15:0]    result_q, result_d;
    logic           pass_q, pass_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [15:0]    sample_res;

    // Next-state: idle/run/finish sequencing, settle counting and capture
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        settle_d   = settle_q;
        result_d   = result_q;
        pass_d     = pass_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        sample_res = result_q;
        sample_res[idx_q] = o_i;
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d  = S_RUN;
                    idx_d    = 4'd0;
                    settle_d = '0;
                    result_d = 16'h0000;
                    busy_d   = 1'b1;
                end
            end
            S_RUN: begin
                if (abort) begin
                    // Partial capture is kept for debug; no done pulse.
                    state_d  = S_IDLE;
                    idx_d    = 4'd0;
                    settle_d = '0;
                    busy_d   = 1'b0;
                end else if (settle_q != SETTLE_LAST) begin
                    settle_d = settle_q + 1'b1;
                end else begin
                    result_d = sample_res;
                    settle_d = '0;
                    if (idx_q == 4'hF) begin
                        state_d = S_FIN;
                        idx_d   = 4'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (sample_res == EXPECTED);
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            idx_q    <= 4'd0;
            settle_q <= '0;
            result_q <= 16'h0000;
            pass_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            result_q <= result_d;
            pass_q   <= pass_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign {a, b, c, d} = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign result       = result_q;
    assign pass         = pass_q;

endmodule

// File: tb/tb_combo_sweep_ctrl.sv
`timescale 1ns/1ps
// tb_combo_sweep_ctrl: scoreboard bench for the sweep sequencer.
// Two instances: SETTLE=1 (dut1) and SETTLE=0 (dut0).
module tb_combo_sweep_ctrl;

    typedef struct {
        logic [15:0] res;
        logic        pass;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start1, abort1, start0, abort0;
    logic        tie0;
    logic        sel0;
    logic        a1, b1, c1, d1, o1, busy1, done1, pass1;
    logic        a0, b0, c0, d0, o0, busy0, done0, pass0;
    logic [15:0] result1, result0;
    logic        m_busy, m_done, m_pass;
    logic [3:0]  m_abcd;
    logic [15:0] m_result;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Behavioural combo: o = ~((a&b)|(c^d))
    assign o1 = tie0 ? 1'b0 : ~((a1 & b1) | (c1 ^ d1));
    assign o0 = ~((a0 & b0) | (c0 ^ d0));

    assign m_busy   = sel0 ? busy0 : busy1;
    assign m_done   = sel0 ? done0 : done1;
    assign m_pass   = sel0 ? pass0 : pass1;
    assign m_abcd   = sel0 ? {a0, b0, c0, d0} : {a1, b1, c1, d1};
    assign m_result = sel0 ? result0 : result1;

    combo_sweep_ctrl #(.SETTLE(1), .EXPECTED(16'h0999)) dut1 (
        .clk(clk), .rstn(rstn), .start(start1), .abort(abort1),
        .a(a1), .b(b1), .c(c1), .d(d1), .o_i(o1),
        .busy(busy1), .done(done1), .result(result1), .pass(pass1)
    );

    combo_sweep_ctrl #(.SETTLE(0), .EXPECTED(16'h0999)) dut0 (
        .clk(clk), .rstn(rstn), .start(start0), .abort(abort0),
        .a(a0), .b(b0), .c(c0), .d(d0), .o_i(o0),
        .busy(busy0), .done(done0), .result(result0), .pass(pass0)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] golden(input bit zero);
        logic [15:0] t;
        logic [3:0]  v;
        t = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            t[i] = zero ? 1'b0 : ~((v[3] & v[2]) | (v[1] ^ v[0]));
        end
        return t;
    endfunction

    task automatic push_exp(input bit zero);
        exp_t e;
        e.res  = golden(zero);
        e.pass = (e.res == 16'h0999);
        sb.push_back(e);
    endtask

    // Called one sample after the start edge; returns one cycle after done.
    task automatic sweep_wait(input int settle);
        int   n;
        int   bcnt;
        bit   seen;
        exp_t e;
        n    = 0;
        bcnt = 0;
        seen = 0;
        while (n < 200 && !seen) begin
            if (m_done) begin
                seen = 1;
            end else begin
                if (n < 16 * (settle + 1))
                    check("abcd", 32'(m_abcd), 32'(n / (settle + 1)));
                if (m_busy) bcnt++;
                step();
                n++;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("done_lat", 32'(n), 32'(16 * (settle + 1)));
        check("busy_cyc", 32'(bcnt), 32'(16 * (settle + 1)));
        check("busy_at_done", 32'(m_busy), 32'd0);
        check("abcd_at_done", 32'(m_abcd), 32'd0);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("result", 32'(m_result), 32'(e.res));
            check("pass", 32'(m_pass), 32'(e.pass));
        end
        step();
        check("done_pulse", 32'(m_done), 32'd0);
    endtask

    initial begin
        rstn   = 1'b0;
        start1 = 1'b0;
        abort1 = 1'b0;
        start0 = 1'b0;
        abort0 = 1'b0;
        tie0   = 1'b0;
        sel0   = 1'b0;
        #12;
        check("rst_state1", {27'd0, a1, b1, c1, d1, busy1, done1, result1, pass1}, 32'd0);
        check("rst_state0", {27'd0, a0, b0, c0, d0, busy0, done0, result0, pass0}, 32'd0);
        rstn = 1'b1;
        step();

        // Normal sweep with real combo
        push_exp(1'b0);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("busy_after_start", 32'(busy1), 32'd1);
        sweep_wait(1);

        // o_i tied low
        tie0 = 1'b1;
        push_exp(1'b1);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        sweep_wait(1);
        tie0 = 1'b0;

        // start held high through a sweep
        push_exp(1'b0);
        push_exp(1'b0);
        start1 = 1'b1;
        step();
        sweep_wait(1);
        check("held_idle_busy", 32'(busy1), 32'd0);
        check("held_idle_done", 32'(done1), 32'd0);
        step();
        check("held_restart", 32'(busy1), 32'd1);
        start1 = 1'b0;
        sweep_wait(1);

        // abort + start together in IDLE: abort wins
        start1 = 1'b1;
        abort1 = 1'b1;
        step();
        start1 = 1'b0;
        abort1 = 1'b0;
        check("abort_start_idle", 32'(busy1), 32'd0);

        // abort at vector 6
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int k = 0; k < 40 && {a1, b1, c1, d1} != 4'd6; k++) step();
        check("reach_vec6", 32'({a1, b1, c1, d1}), 32'd6);
        abort1 = 1'b1;
        step();
        abort1 = 1'b0;
        check("abort_busy", 32'(busy1), 32'd0);
        check("abort_abcd", 32'({a1, b1, c1, d1}), 32'd0);
        check("abort_result", 32'(result1), 32'h0019);
        check("abort_pass", 32'(pass1), 32'd1);
        for (int k = 0; k < 40; k++) begin
            if (done1) check("abort_no_done", 32'(done1), 32'd0);
            step();
        end
        check("abort_idle", 32'(busy1), 32'd0);

        // reset at vector 9
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int k = 0; k < 40 && {a1, b1, c1, d1} != 4'd9; k++) step();
        check("reach_vec9", 32'({a1, b1, c1, d1}), 32'd9);
        #2;
        rstn = 1'b0;
        #1;
        check("async_rst", {27'd0, a1, b1, c1, d1, busy1, done1, result1, pass1}, 32'd0);
        step();
        step();
        rstn = 1'b1;
        step();
        check("post_rst_idle", 32'(busy1), 32'd0);
        push_exp(1'b0);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        sweep_wait(1);

        // SETTLE=0 instance
        sel0 = 1'b1;
        push_exp(1'b0);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        sweep_wait(0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
